onchip_ram_ctrl: RTL and testbench

- Parametrised successor to the Qsys on-chip single-port RAM slave.
- Infers a byte-enabled single-port RAM of 2**ADDR_W words × DATA_W bits behind an Avalon-MM slave with pipelined reads (waitrequest/readdatavalid).
- Adds what the fixed-size version lacks: selectable read latency, a hardware clear engine (after reset and on request), and clock-enable stalls.
- Sits on the Nios II data/instruction master as program/data memory.

---
 rtl/onchip_ram_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_onchip_ram_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_ctrl.sv
// ---------------------------------------------------------------------------
// onchip_ram_ctrl
//   Byte-enabled single-port on-chip RAM (2**ADDR_W x DATA_W) behind an
//   Avalon-MM slave with pipelined reads. Adds a selectable read latency
//   (1 or 2 cycles), a hardware clear engine (after reset and on request)
//   and a global clock enable that freezes the whole block.
//
//   Optional feature: define ONCHIP_RAM_PARITY_EN to store one even-parity
//   bit per byte and check it on every returned read word.
//
// Ports
//   clk            single clock
//   reset_n        synchronous active-low reset
//   address        word address
//   byteenable     per-byte write enables
//   chipselect     slave select
//   read / write   transfer requests (write wins when both are set)
//   writedata      write data
//   readdata       read data, valid only with readdatavalid
//   readdatavalid  one-cycle pulse per accepted read
//   waitrequest    transfer not accepted this cycle
//   clken          global clock enable, 0 freezes the block
//   clear_req      single-cycle pulse requesting a full memory clear
//   init_busy      high while draining reads or clearing memory
//   parity_err     (parity build) sticky parity error flag
//   parity_addr    (parity build) address of the first parity error
// ---------------------------------------------------------------------------
module onchip_ram_ctrl #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 14,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    input  logic                  clken,
    input  logic                  clear_req,
    output logic                  init_busy
`ifdef ONCHIP_RAM_PARITY_EN
    ,
    output logic                  parity_err,
    output logic [ADDR_W-1:0]     parity_addr
`endif
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                pipe_busy;
    logic                pipe_valid;
    logic [DATA_W-1:0]   pipe_data;

    // A transfer is only taken in RUN with the clock enabled, and never in the
    // cycle that requests a clear (that cycle already reports waitrequest).
    assign accept = (state == S_RUN) & clken & ~clear_req & chipselect & (read | write);
    assign wr_acc = accept & write;
    assign rd_acc = accept & read & ~write;

    assign waitrequest   = (state != S_RUN) | ~clken | clear_req;
    assign init_busy     = (state != S_RUN);
    assign readdata      = pipe_data;
    // A pending pulse is held in the pipeline while clken=0 and shown once it returns.
    assign readdatavalid = pipe_valid & clken;

    // ---------------------------------------------------------------------
    // Control FSM and clear counter
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt <= '0;
        end else if (clken) begin
            case (state)
                S_CLEAR: begin
                    if (&clr_cnt) state <= S_RUN;   // last location written, no wrap
                    else          clr_cnt <= clr_cnt + ADDR_W'(1);
                end
                S_RUN: begin
                    if (clear_req) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!pipe_busy) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array itself has no reset so it maps onto block RAM; only the
    // clear engine initialises it.
    always_ff @(posedge clk) begin
        if (reset_n && clken) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= CLEAR_VALUE;
            end else if (wr_acc) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NBYTES-1:0] par_mem [DEPTH];
    logic [NBYTES-1:0] p1;
    logic [ADDR_W-1:0] a1;
    logic [NBYTES-1:0] pipe_par;
    logic [ADDR_W-1:0] pipe_addr;

    // Even parity: the stored bit makes each byte-plus-bit hold an even count of ones.
    function automatic logic [NBYTES-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NBYTES-1:0] p;
        for (int b = 0; b < NBYTES; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset_n && clken) begin
            if (state == S_CLEAR) begin
                par_mem[clr_cnt] <= byte_par(CLEAR_VALUE);
            end else if (wr_acc) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (byteenable[b]) par_mem[address][b] <= ^writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p1 <= '0;
            a1 <= '0;
        end else if (clken && rd_acc) begin
            p1 <= par_mem[address];
            a1 <= address;
        end
    end

    // Sticky flag; only the first failing address is kept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_err  <= 1'b0;
            parity_addr <= '0;
        end else if (readdatavalid && !parity_err && (byte_par(pipe_data) != pipe_par)) begin
            parity_err  <= 1'b1;
            parity_addr <= pipe_addr;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Read pipeline: stage 1 is the RAM output register
    // ---------------------------------------------------------------------
    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (clken) begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= mem[address];
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              v2;
            logic [DATA_W-1:0] d2;
`ifdef ONCHIP_RAM_PARITY_EN
            logic [NBYTES-1:0] p2;
            logic [ADDR_W-1:0] a2;
`endif
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
                    p2 <= '0;
                    a2 <= '0;
`endif
                end else if (clken) begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
`ifdef ONCHIP_RAM_PARITY_EN
                        p2 <= p1;
                        a2 <= a1;
`endif
                    end
                end
            end
            assign pipe_valid = v2;
            assign pipe_data  = d2;
            assign pipe_busy  = v1 | v2;
`ifdef ONCHIP_RAM_PARITY_EN
            assign pipe_par   = p2;
            assign pipe_addr  = a2;
`endif
        end else begin : g_lat1
            assign pipe_valid = v1;
            assign pipe_data  = d1;
            assign pipe_busy  = v1;
`ifdef ONCHIP_RAM_PARITY_EN
            assign pipe_par   = p1;
            assign pipe_addr  = a1;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_onchip_ram_ctrl
//   Two instances (READ_LATENCY 1 and 2, ADDR_W=4) share one stimulus.
//   Directed vector table plus hand-written sequences for stalls, clear
//   requests and reset in the middle of a clear. A per-instance scoreboard
//   checks read data and the exact cycle of every readdatavalid pulse.
// ---------------------------------------------------------------------------
module tb_onchip_ram_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, chipselect, read, write, clken, clear_req;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [DW-1:0] writedata;

    logic [1:0][DW-1:0] rdata;
    logic [1:0]         rdv, wreq, ibusy;
`ifdef ONCHIP_RAM_PARITY_EN
    logic [1:0]         perr;
    logic [1:0][AW-1:0] paddr;
`endif

    onchip_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1),
                      .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]),
        .clken(clken), .clear_req(clear_req), .init_busy(ibusy[0])
`ifdef ONCHIP_RAM_PARITY_EN
        , .parity_err(perr[0]), .parity_addr(paddr[0])
`endif
    );

    onchip_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2),
                      .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]),
        .clken(clken), .clear_req(clear_req), .init_busy(ibusy[1])
`ifdef ONCHIP_RAM_PARITY_EN
        , .parity_err(perr[1]), .parity_addr(paddr[1])
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sb [2][$];
    logic [31:0] drv_exp     = '0;
    int          stall_extra = 0;

    // Accepted reads are detected on the negedge before the accepting posedge;
    // the pulse is due READ_LATENCY (+ stall) cycles after that posedge.
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) sb[k].delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rdv[k]) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("rdv_unexpected_lat%0d", k + 1), 32'(rdv[k]), 32'd0);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("rdata_lat%0d", k + 1), rdata[k], e.data);
                        check($sformatf("rdv_cycle_lat%0d", k + 1), 32'(cyc), 32'(e.due));
                    end
                end else if (sb[k].size() != 0 && cyc > sb[k][0].due) begin
                    check($sformatf("rdv_missing_lat%0d", k + 1), 32'(rdv[k]), 32'd1);
                    void'(sb[k].pop_front());
                end
                if (chipselect && read && !write && !wreq[k])
                    sb[k].push_back('{drv_exp, cyc + k + 1 + stall_extra});
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        cs, rd, wr;
        logic [3:0]  addr, be;
        logic [31:0] wdata, exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ex);
        vecs.push_back('{cs, rd, wr, a, be, wd, ex});
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; clear_req = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk); #1;
            chipselect = vecs[i].cs;    read      = vecs[i].rd;    write = vecs[i].wr;
            address    = vecs[i].addr;  byteenable = vecs[i].be;
            writedata  = vecs[i].wdata; drv_exp   = vecs[i].exp;
            @(negedge clk);
            if (vecs[i].cs && (vecs[i].rd || vecs[i].wr))
                for (int k = 0; k < 2; k++)
                    check($sformatf("vec%0d_waitrequest_lat%0d", i, k + 1), 32'(wreq[k]), 32'd0);
        end
        idle(1);
    endtask

    // Counts, over 40 negedges, the cycles each instance holds a flag high.
    task automatic count_high(input bit use_busy, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n0 += use_busy ? int'(ibusy[0]) : int'(wreq[0]);
            n1 += use_busy ? int'(ibusy[1]) : int'(wreq[1]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int a_end, b_end, c_end;
        int n0, n1;

        // Phase A: after the power-up clear
        for (int a = 0; a < DEPTH; a++) add(1, 1, 0, 4'(a), 4'h0, 32'h0, 32'h0);
        add(1, 0, 1, 4'h5, 4'hF, 32'hDEADBEEF, 32'h0);
        add(1, 0, 1, 4'h5, 4'h1, 32'h000000AA, 32'h0);
        add(1, 1, 0, 4'h5, 4'h0, 32'h0,        32'hDEADBEAA);
        add(1, 0, 1, 4'h6, 4'hF, 32'h11223344, 32'h0);
        add(1, 0, 1, 4'h6, 4'hA, 32'hAABBCCDD, 32'h0);
        add(1, 1, 0, 4'h6, 4'h0, 32'h0,        32'hAA22CC44);
        add(1, 1, 1, 4'h6, 4'h1, 32'h55555555, 32'h0);          // write wins, no pulse
        add(1, 1, 0, 4'h6, 4'h0, 32'h0,        32'hAA22CC55);
        add(0, 0, 1, 4'h5, 4'hF, 32'hFFFFFFFF, 32'h0);          // not selected
        add(1, 1, 0, 4'h5, 4'h0, 32'h0,        32'hDEADBEAA);
        add(1, 0, 1, 4'h0, 4'hF, 32'hA0A0A0A0, 32'h0);
        add(1, 0, 1, 4'h1, 4'hF, 32'hB1B1B1B1, 32'h0);
        add(1, 0, 1, 4'h2, 4'hF, 32'hC2C2C2C2, 32'h0);
        add(1, 0, 1, 4'h3, 4'hF, 32'hD3D3D3D3, 32'h0);
        add(1, 1, 0, 4'h0, 4'h0, 32'h0,        32'hA0A0A0A0);   // back-to-back reads
        add(1, 1, 0, 4'h1, 4'h0, 32'h0,        32'hB1B1B1B1);
        add(1, 1, 0, 4'h2, 4'h0, 32'h0,        32'hC2C2C2C2);
        add(1, 1, 0, 4'h3, 4'h0, 32'h0,        32'hD3D3D3D3);
        add(1, 0, 1, 4'h7, 4'hF, 32'h12345678, 32'h0);
        add(1, 1, 0, 4'h7, 4'h0, 32'h0,        32'h12345678);
        a_end = vecs.size();
        // Phase B: after a requested clear
        add(1, 1, 0, 4'h5, 4'h0, 32'h0,        32'h0);
        add(1, 1, 0, 4'h6, 4'h0, 32'h0,        32'h0);
        add(1, 1, 0, 4'h0, 4'h0, 32'h0,        32'h0);
        add(1, 1, 0, 4'h7, 4'h0, 32'h0,        32'h0);
        add(1, 0, 1, 4'hC, 4'hF, 32'hCAFEF00D, 32'h0);
        add(1, 1, 0, 4'hC, 4'h0, 32'h0,        32'hCAFEF00D);
        b_end = vecs.size();
        // Phase C: after reset in the middle of a clear
        add(1, 1, 0, 4'hC, 4'h0, 32'h0,        32'h0);
        add(1, 1, 0, 4'h7, 4'h0, 32'h0,        32'h0);
        add(1, 1, 0, 4'hF, 4'h0, 32'h0,        32'h0);
        c_end = vecs.size();

        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        clken = 1'b1; clear_req = 1'b0; address = '0; byteenable = '0; writedata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_readdata_lat%0d", k + 1),      rdata[k],       32'h0);
            check($sformatf("reset_readdatavalid_lat%0d", k + 1), 32'(rdv[k]),   32'd0);
            check($sformatf("reset_waitrequest_lat%0d", k + 1),   32'(wreq[k]),  32'd1);
            check($sformatf("reset_init_busy_lat%0d", k + 1),     32'(ibusy[k]), 32'd1);
        end

        @(posedge clk); #1;
        reset_n = 1'b1;
        count_high(1'b0, n0, n1);
        check("powerup_clear_wait_lat1", 32'(n0), 32'(DEPTH));
        check("powerup_clear_wait_lat2", 32'(n1), 32'(DEPTH));

        run_vecs(0, a_end);
        idle(4);

        // Read in flight, then clken low for 3 cycles
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = 4'h5; drv_exp = 32'hDEADBEAA; stall_extra = 3;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0; clken = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("stall%0d_waitrequest_lat%0d", s, k + 1), 32'(wreq[k]), 32'd1);
                check($sformatf("stall%0d_rdv_lat%0d", s, k + 1),         32'(rdv[k]),  32'd0);
            end
        end
        @(posedge clk); #1;
        clken = 1'b1; stall_extra = 0;
        idle(5);

        // Read in flight, then clear_req with a read presented in the same cycle
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = 4'h5; drv_exp = 32'hDEADBEAA;
        @(posedge clk); #1;
        clear_req = 1'b1; address = 4'h9; drv_exp = 32'hBAD0BAD0;
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("clear_req_waitrequest_lat%0d", k + 1), 32'(wreq[k]), 32'd1);
        @(posedge clk); #1;
        clear_req = 1'b0; chipselect = 1'b0; read = 1'b0;
        count_high(1'b1, n0, n1);
        check("clear_busy_min_lat1", 32'(n0 >= DEPTH + 1), 32'd1);
        check("clear_busy_max_lat1", 32'(n0 <= DEPTH + 1), 32'd1);
        check("clear_busy_min_lat2", 32'(n1 >= DEPTH + 1), 32'd1);
        check("clear_busy_max_lat2", 32'(n1 <= DEPTH + 2), 32'd1);

        run_vecs(a_end, b_end);
        idle(4);

        // Reset part-way through a clear restarts it from address 0
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        count_high(1'b0, n0, n1);
        check("midclear_reset_wait_lat1", 32'(n0), 32'(DEPTH));
        check("midclear_reset_wait_lat2", 32'(n1), 32'(DEPTH));

        run_vecs(b_end, c_end);
        idle(4);

`ifdef ONCHIP_RAM_PARITY_EN
        dut1.mem[3] = dut1.mem[3] ^ 32'h1;
        dut2.mem[3] = dut2.mem[3] ^ 32'h1;
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = 4'h3; drv_exp = 32'h1;
        idle(5);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("parity_err_lat%0d", k + 1),  32'(perr[k]),  32'd1);
            check($sformatf("parity_addr_lat%0d", k + 1), 32'(paddr[k]), 32'h3);
        end
`endif

        idle(6);
        for (int k = 0; k < 2; k++)
            check($sformatf("scoreboard_empty_lat%0d", k + 1), 32'(sb[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
